io_serial_tx: RTL and testbench

Device-side responder for the CPU's memory-mapped I/O ports. It consumes a command word that the CPU writes into an output port register and serialises one byte per command onto a UART-style line (8N1). It returns busy, acknowledge, and frame-count status through a word that is wired to a CPU input port. The CPU uses a toggle handshake: it writes a command, then polls the input port until the ack bit matches the request bit it sent.

---
 rtl/io_serial_tx.sv | 148 ++++++++++++++
 tb/tb_io_serial_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/io_serial_tx.sv
// rtl/io_serial_tx.sv - CPU I/O-port responder serialising one 8N1 byte per toggle-handshake command
module io_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] out_port,
    output logic [31:0] in_port,
    output logic        txd
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_reg_q, shift_reg_d;
    logic [7:0]      last_data_q, last_data_d;
    logic [7:0]      frame_count_q, frame_count_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;

    logic            bit_end;
    logic            req_pending;
    logic            unused_bits;

    assign unused_bits = ^out_port[31:9];
    assign bit_end     = (baud_cnt_q == BAUD_LAST);
    // A command is pending while the CPU's req toggle disagrees with our ack
    assign req_pending = (state_q == S_IDLE) && (out_port[8] != ack_q);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_pending) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:  if (bit_end && (bit_idx_q == LAST_BIT)) state_d = S_STOP;
            S_STOP:  if (bit_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        baud_cnt_d    = baud_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_reg_d   = shift_reg_q;
        last_data_d   = last_data_q;
        frame_count_d = frame_count_q;
        txd_d         = txd_q;
        busy_d        = busy_q;
        ack_d         = ack_q;
        case (state_q)
            S_IDLE: begin
                txd_d      = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = '0;
                if (req_pending) begin
                    shift_reg_d = out_port[7:0];
                    last_data_d = out_port[7:0];
                    busy_d      = 1'b1;
                    txd_d       = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    txd_d      = shift_reg_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        txd_d = 1'b1;
                    end else begin
                        shift_reg_d = {1'b0, shift_reg_q[7:1]};
                        txd_d       = shift_reg_q[1];
                        bit_idx_d   = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_d    = '0;
                    ack_d         = ~ack_q;
                    busy_d        = 1'b0;
                    frame_count_d = frame_count_q + 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            baud_cnt_q    <= '0;
            bit_idx_q     <= '0;
            shift_reg_q   <= '0;
            last_data_q   <= '0;
            frame_count_q <= '0;
            txd_q         <= 1'b1;
            busy_q        <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            baud_cnt_q    <= baud_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_reg_q   <= shift_reg_d;
            last_data_q   <= last_data_d;
            frame_count_q <= frame_count_d;
            txd_q         <= txd_d;
            busy_q        <= busy_d;
            ack_q         <= ack_d;
        end
    end

    assign txd     = txd_q;
    assign in_port = {8'h00, last_data_q, frame_count_q, 6'b0, ack_q, busy_q};

endmodule

// File: tb/tb_io_serial_tx.sv
// tb/tb_io_serial_tx.sv - scoreboard bench for io_serial_tx with CLKS_PER_BIT=4
module tb_io_serial_tx;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] out_port;
    logic [31:0] in_port;
    logic        txd;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          starts[$];
    logic [7:0]  mon_byte;
    logic [7:0]  mon_exp;
    bit          mon_abort;

    io_serial_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .out_port(out_port),
        .in_port (in_port),
        .txd     (txd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Receiver: samples each bit at its centre and pops the expected byte
    always begin
        @(negedge clock);
        if (resetn === 1'b1 && txd === 1'b0) begin
            starts.push_back(cyc);
            mon_abort = 1'b0;
            mon_byte  = 8'h00;
            for (int c = 1; c <= 9 * CPB + CPB / 2; c++) begin
                @(negedge clock);
                if (resetn !== 1'b1) mon_abort = 1'b1;
                for (int i = 0; i < 8; i++)
                    if (c == CPB * (1 + i) + CPB / 2) mon_byte[i] = txd;
            end
            if (!mon_abort) begin
                check("stop_bit", {31'b0, txd}, 32'h1);
                check("sb_depth", {31'b0, exp_q.size() > 0}, 32'h1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check("rx_byte", {24'b0, mon_byte}, {24'b0, mon_exp});
                end
            end
        end
    end

    initial begin
        int n;
        int lows;
        logic [7:0] d;
        logic r;

        resetn   = 1'b0;
        out_port = 32'h1FF;
        repeat (3) @(negedge clock);
        resetn   = 1'b1;
        out_port = 32'h0;
        check("rst_in_port", in_port, 32'h0);
        check("rst_txd", {31'b0, txd}, 32'h1);
        lows = 0;
        repeat (100) begin
            @(negedge clock);
            if (txd !== 1'b1 || in_port !== 32'h0) lows++;
        end
        check("rst_quiet", lows, 0);

        // Frame 0xA5; mid-frame data change ignored, then req=0 pre-armed for back-to-back
        out_port = 32'h1A5;
        exp_q.push_back(8'hA5);
        @(negedge clock);
        check("start_busy", {31'b0, in_port[0]}, 32'h1);
        check("start_txd", {31'b0, txd}, 32'h0);
        n = 1;
        while (in_port[1] !== 1'b1 && n < 200) begin
            @(negedge clock);
            if (in_port[0] === 1'b1) begin
                n++;
                if (n == 12) out_port = 32'h13C;
                if (n == 30) begin
                    out_port = 32'h03C;
                    exp_q.push_back(8'h3C);
                end
                if (n == 35) check("last_data_hold", {24'b0, in_port[23:16]}, 32'hA5);
            end
        end
        check("busy_cycles", n, 10 * CPB);
        check("frame1_status", in_port, 32'h00A50102);
        @(negedge clock);
        check("b2b_busy", {31'b0, in_port[0]}, 32'h1);
        n = 0;
        while (in_port[1] !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("frame2_status", in_port, 32'h003C0200);
        check("b2b_starts", starts.size(), 2);
        if (starts.size() >= 2) check("b2b_gap", starts[1] - starts[0], 10 * CPB + 1);

        // Reset during data bit 3
        @(negedge clock);
        out_port = 32'h155;
        @(negedge clock);
        repeat (CPB * 4 + 1) @(negedge clock);
        check("mid_busy", {31'b0, in_port[0]}, 32'h1);
        resetn = 1'b0;
        @(negedge clock);
        check("mid_rst_txd", {31'b0, txd}, 32'h1);
        check("mid_rst_in_port", in_port, 32'h0);
        resetn   = 1'b1;
        out_port = 32'h0;
        lows = 0;
        repeat (50) begin
            @(negedge clock);
            if (txd !== 1'b1 || in_port !== 32'h0) lows++;
        end
        check("post_rst_idle", lows, 0);

        // 256 handshaked frames to wrap frame_count
        for (int k = 1; k <= 256; k++) begin
            d = 8'(k) ^ 8'h5A;
            r = k[0];
            @(negedge clock);
            out_port = {23'b0, r, d};
            exp_q.push_back(d);
            n = 0;
            while (in_port[1] !== r && n < 200) begin
                @(negedge clock);
                n++;
            end
            check("wrap_ack", {31'b0, in_port[1]}, {31'b0, r});
            if (k == 255) check("count_255", {24'b0, in_port[15:8]}, 32'hFF);
            if (k == 256) begin
                check("count_wrap", {24'b0, in_port[15:8]}, 32'h00);
                check("ack_parity", {31'b0, in_port[1]}, 32'h0);
            end
        end
        repeat (20) @(negedge clock);
        check("sb_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
